// File: rtl/addr_stack_pkg.sv
// addr_stack_pkg: shared defaults and status-word layout for the return-address stack.
package addr_stack_pkg;
    localparam int ADDR_STACK_WIDTH = 16;
    localparam int ADDR_STACK_DEPTH = 16;
    localparam int STAT_EMPTY_BIT     = 0;
    localparam int STAT_FULL_BIT      = 1;
    localparam int STAT_OVERFLOW_BIT  = 2;
    localparam int STAT_UNDERFLOW_BIT = 3;

    function automatic logic [3:0] pack_status(input logic unf, input logic ovf,
                                               input logic ful, input logic emp);
        logic [3:0] s;
        s = '0;
        s[STAT_UNDERFLOW_BIT] = unf;
        s[STAT_OVERFLOW_BIT]  = ovf;
        s[STAT_FULL_BIT]      = ful;
        s[STAT_EMPTY_BIT]     = emp;
        return s;
    endfunction
endpackage

// File: rtl/stack_regfile.sv
// stack_regfile: DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset.
module stack_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/addr_stack.sv
// addr_stack: bus-mapped return-address stack; write pushes din, read pops the top.
// Sticky overflow/underflow flags exist only when ADDR_STACK_ERR_EN is defined.
module addr_stack
    import addr_stack_pkg::*;
#(
    parameter int WIDTH = ADDR_STACK_WIDTH,
    parameter int DEPTH = ADDR_STACK_DEPTH,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             sel,
    input  logic             write,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);
    localparam int AW = CW - 1;

    logic [CW-1:0]    count_q, count_d;
    logic             sel_q;
    logic             access, push, pop;
    logic [WIDTH-1:0] rdata;

    // One access per select assertion; sel_q resets high so a held sel never fires.
    assign access = sel & ~sel_q;
    assign empty  = count_q == '0;
    assign full   = count_q == CW'(DEPTH);
    assign push   = access & write & ~full;
    assign pop    = access & ~write & ~empty;
    assign count  = count_q;

    always_comb begin
        count_d = push ? count_q + CW'(1) : pop ? count_q - CW'(1) : count_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
            sel_q   <= 1'b1;
        end else begin
            count_q <= count_d;
            sel_q   <= sel;
        end
    end

    stack_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_regfile (
        .clk_i  (CLK),
        .we_i   (push),
        .waddr_i(AW'(count_q)),
        .wdata_i(din),
        .raddr_i(AW'(count_q - CW'(1))),
        .rdata_o(rdata)
    );

    assign dout = empty ? '0 : rdata;

`ifdef ADDR_STACK_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // A new error outranks a simultaneous clear.
    always_comb begin
        ovf_d = (access & write & full) | (ovf_q & ~err_clr);
        unf_d = (access & ~write & empty) | (unf_q & ~err_clr);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif
endmodule
